// File: rtl/tm1638_tx.sv
// rtl/tm1638_tx.sv - shifts one 8-digit segment frame to a TM1638 over stb/clko/dio
// Optional: define TM1638_LED_EN to add led[7:0], which drives the odd (LED) bytes.
module tm1638_tx #(
  parameter int         CLK_DIV = 25,
  parameter logic [2:0] BRIGHT  = 3'd7
) (
  input  logic        clki,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] seg_data,
`ifdef TM1638_LED_EN
  input  logic [7:0]  led,
`endif
  output logic        busy,
  output logic        done,
  output logic        clko,
  output logic        stb,
  output logic        dio
);

  localparam int            DW       = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] BIT_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] HALF     = DW'(CLK_DIV);
  localparam logic [7:0]    CMD_DATA = 8'h40;
  localparam logic [7:0]    CMD_ADDR = 8'hC0;
  localparam logic [7:0]    CMD_DISP = 8'h88 | {5'd0, BRIGHT};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [63:0]   seg_q, seg_d;
`ifdef TM1638_LED_EN
  logic [7:0]    led_q, led_d;
`endif
  logic [1:0]    frame_q, frame_d;
  logic [4:0]    byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    sh_q, sh_d;
  logic          stb_q, stb_d, clko_q, clko_d, dio_q, dio_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [7:0]    next_byte;
  logic [7:0]    cmd_next;
  logic [DW-1:0] div_inc;

  // byte_q counts data bytes already sent in frame 2; even = digit, odd = LED byte
  always_comb begin
    next_byte = seg_q[{byte_q[3:1], 3'b000} +: 8];
    if (byte_q[0]) begin
`ifdef TM1638_LED_EN
      next_byte = {7'b0, led_q[byte_q[3:1]]};
`else
      next_byte = 8'h00;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
`ifdef TM1638_LED_EN
    led_d    = led_q;
`endif
    frame_d  = frame_q;
    byte_d   = byte_q;
    bit_d    = bit_q;
    div_d    = div_q;
    sh_d     = sh_q;
    stb_d    = stb_q;
    clko_d   = clko_q;
    dio_d    = dio_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div_inc  = div_q + DW'(1);
    cmd_next = (frame_q == 2'd0) ? CMD_ADDR : CMD_DISP;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        stb_d   = 1'b1;
        clko_d  = 1'b1;
        dio_d   = 1'b1;
        busy_d  = 1'b0;
        if (start) begin
          state_d = S_LOAD;
          seg_d   = seg_data;
`ifdef TM1638_LED_EN
          led_d   = led;
`endif
          frame_d = 2'd0;
          byte_d  = 5'd0;
          bit_d   = 3'd0;
          div_d   = '0;
          sh_d    = CMD_DATA;
          stb_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      // First frame: LOAD is a pure stb-to-clk setup cycle. Later frames: LOAD
      // already drives the first low half-cycle of bit 0.
      S_LOAD: begin
        state_d = S_SHIFT;
        bit_d   = 3'd0;
        dio_d   = sh_q[0];
        if (frame_q == 2'd0) begin
          div_d  = '0;
          clko_d = 1'b0;
        end else begin
          div_d  = DW'(1);
          clko_d = (HALF <= DW'(1));
        end
      end

      S_SHIFT: begin
        if (div_q == BIT_LAST) begin
          div_d  = '0;
          clko_d = 1'b0;
          if (bit_q != 3'd7) begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            dio_d = sh_q[1];
          end else if (frame_q == 2'd1 && byte_q != 5'd16) begin
            bit_d  = 3'd0;
            byte_d = byte_q + 5'd1;
            sh_d   = next_byte;
            dio_d  = next_byte[0];
          end else begin
            state_d = S_GAP;
            stb_d   = 1'b1;
            clko_d  = 1'b1;
            dio_d   = 1'b1;
          end
        end else begin
          div_d  = div_inc;
          clko_d = (div_inc >= HALF);
        end
      end

      S_GAP: begin
        if (div_q == BIT_LAST) begin
          div_d = '0;
          if (frame_q == 2'd2) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_LOAD;
            frame_d = frame_q + 2'd1;
            byte_d  = 5'd0;
            sh_d    = cmd_next;
            stb_d   = 1'b0;
            clko_d  = 1'b0;
            dio_d   = cmd_next[0];
          end
        end else begin
          div_d = div_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state_q <= S_IDLE;
      seg_q   <= '0;
`ifdef TM1638_LED_EN
      led_q   <= '0;
`endif
      frame_q <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sh_q    <= '0;
      stb_q   <= 1'b1;
      clko_q  <= 1'b1;
      dio_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
`ifdef TM1638_LED_EN
      led_q   <= led_d;
`endif
      frame_q <= frame_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      sh_q    <= sh_d;
      stb_q   <= stb_d;
      clko_q  <= clko_d;
      dio_q   <= dio_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stb  = stb_q;
  assign clko = clko_q;
  assign dio  = dio_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_tm1638_tx.sv
// tb/tb_tm1638_tx.sv - scoreboard bench for tm1638_tx, CLK_DIV=2, BRIGHT=7 and BRIGHT=3 instances
`timescale 1ns/1ps
module tb_tm1638_tx;

  localparam int D          = 2;
  localparam int FRAME_BUSY = 152*2*D + 3*2*D + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [63:0] seg_data;
  logic [7:0]  led;
  logic        busy0, done0, clko0, stb0, dio0;
  logic        busy1, done1, clko1, stb1, dio1;

  tm1638_tx #(.CLK_DIV(D), .BRIGHT(3'd7)) dut0 (
    .clki(clk), .rst(rst), .start(start), .seg_data(seg_data),
`ifdef TM1638_LED_EN
    .led(led),
`endif
    .busy(busy0), .done(done0), .clko(clko0), .stb(stb0), .dio(dio0)
  );

  tm1638_tx #(.CLK_DIV(D), .BRIGHT(3'd3)) dut1 (
    .clki(clk), .rst(rst), .start(start), .seg_data(seg_data),
`ifdef TM1638_LED_EN
    .led(led),
`endif
    .busy(busy1), .done(done1), .clko(clko1), .stb(stb1), .dio(dio1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  int win0 = 0, win1 = 0, done_cnt = 0, done_bad = 0;
  int busy_run = 0, busy_len = 0, setup_bad = 0, hold_bad = 0;

  logic p_clko0 = 1'b1, p_stb0 = 1'b1, p_dio0 = 1'b1, p_busy0 = 1'b0;
  logic p_clko1 = 1'b1, p_stb1 = 1'b1;
  logic [7:0] sh0 = 8'h00, sh1 = 8'h00, want;
  int bc0 = 0, bc1 = 0, stable0 = 0, since0 = 1000;

  // Decode both serial streams; each finished byte is popped against the scoreboard.
  always @(negedge clk) begin : mon
    logic rise0, rise1;
    rise0 = clko0 && !p_clko0;
    rise1 = clko1 && !p_clko1;
    if (!stb0 && p_stb0) begin win0++; bc0 = 0; end
    if (!stb1 && p_stb1) begin win1++; bc1 = 0; end

    if (rise0) since0 = 0; else if (since0 < 1000) since0++;
    if (dio0 !== p_dio0) begin
      if (since0 < D) hold_bad++;
      stable0 = 1;
    end else if (stable0 < 1000) stable0++;
    if (rise0 && stable0 < D) setup_bad++;

    if (rise0 && !stb0) begin
      sh0 = {dio0, sh0[7:1]};
      bc0++;
      if (bc0 == 8) begin
        bc0 = 0;
        n_checks++;
        if (exp0.size() == 0) $display("FAIL ch0_byte: got %02h, expected no byte", sh0);
        else begin
          want = exp0.pop_front();
          if (sh0 !== want) $display("FAIL ch0_byte: got %02h, expected %02h", sh0, want);
          else n_pass++;
        end
      end
    end
    if (rise1 && !stb1) begin
      sh1 = {dio1, sh1[7:1]};
      bc1++;
      if (bc1 == 8) begin
        bc1 = 0;
        n_checks++;
        if (exp1.size() == 0) $display("FAIL ch1_byte: got %02h, expected no byte", sh1);
        else begin
          want = exp1.pop_front();
          if (sh1 !== want) $display("FAIL ch1_byte: got %02h, expected %02h", sh1, want);
          else n_pass++;
        end
      end
    end

    if (done0) begin done_cnt++; if (busy0) done_bad++; end
    if (done1 !== done0 || busy1 !== busy0) done_bad++;
    if (busy0) busy_run++;
    else begin
      if (p_busy0) busy_len = busy_run;
      busy_run = 0;
    end

    p_clko0 = clko0; p_stb0 = stb0; p_dio0 = dio0; p_busy0 = busy0;
    p_clko1 = clko1; p_stb1 = stb1;
  end

  task automatic push_frame(input logic [63:0] seg, input logic [7:0] ld);
    logic [7:0] led_b;
    exp0.push_back(8'h40); exp1.push_back(8'h40);
    exp0.push_back(8'hC0); exp1.push_back(8'hC0);
    for (int i = 0; i < 8; i++) begin
      led_b = 8'h00;
`ifdef TM1638_LED_EN
      led_b = {7'b0, ld[i]};
`endif
      exp0.push_back(seg[8*i +: 8]); exp1.push_back(seg[8*i +: 8]);
      exp0.push_back(led_b);         exp1.push_back(led_b);
    end
    exp0.push_back(8'h8F); exp1.push_back(8'h8B);
  endtask

  task automatic pulse_start(input logic [63:0] seg, input logic [7:0] ld);
    @(negedge clk);
    seg_data = seg; led = ld; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seg_data = ~seg; led = ~ld;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic clear_stats();
    win0 = 0; win1 = 0; done_cnt = 0; done_bad = 0;
    setup_bad = 0; hold_bad = 0; busy_len = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; seg_data = '0; led = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({stb0, clko0, dio0, busy0, done0} !== 5'b11100)
        $display("FAIL reset_idle: cycle %0d stb,clko,dio,busy,done=%b, expected 11100", i,
                 {stb0, clko0, dio0, busy0, done0});
      else n_pass++;
    end
  endtask

  task automatic test_frame(input string tag, input logic [63:0] seg, input logic [7:0] ld);
    bit seen;
    clear_stats();
    pulse_start(seg, ld);
    push_frame(seg, ld);
    wait_done(seen);
    n_checks++;
    if (!seen) $display("FAIL %s_done_timeout: got no done, expected one within 2000 cycles", tag); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (win0 !== 3) $display("FAIL %s_windows0: got %0d, expected 3", tag, win0); else n_pass++;
    n_checks++; if (win1 !== 3) $display("FAIL %s_windows1: got %0d, expected 3", tag, win1); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL %s_done_count: got %0d, expected 1", tag, done_cnt); else n_pass++;
    n_checks++; if (done_bad !== 0) $display("FAIL %s_done_busy: got %0d bad cycles, expected 0", tag, done_bad); else n_pass++;
    n_checks++; if (busy_len !== FRAME_BUSY) $display("FAIL %s_busy_len: got %0d, expected %0d", tag, busy_len, FRAME_BUSY); else n_pass++;
    n_checks++; if (exp0.size() !== 0) $display("FAIL %s_missing0: got %0d bytes left, expected 0", tag, exp0.size()); else n_pass++;
    n_checks++; if (exp1.size() !== 0) $display("FAIL %s_missing1: got %0d bytes left, expected 0", tag, exp1.size()); else n_pass++;
    n_checks++; if (setup_bad !== 0) $display("FAIL %s_setup: got %0d violations, expected 0", tag, setup_bad); else n_pass++;
    n_checks++; if (hold_bad !== 0) $display("FAIL %s_hold: got %0d violations, expected 0", tag, hold_bad); else n_pass++;
    n_checks++;
    if ({stb0, clko0, dio0, busy0} !== 4'b1110)
      $display("FAIL %s_idle_after: got %b, expected 1110", tag, {stb0, clko0, dio0, busy0});
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    bit seen;
    clear_stats();
    pulse_start(64'h1122_3344_5566_7788, 8'h00);
    push_frame(64'h1122_3344_5566_7788, 8'h00);
    repeat (150) @(negedge clk);
    pulse_start(64'hFFEE_DDCC_BBAA_9988, 8'hFF);
    wait_done(seen);
    n_checks++;
    if (!seen) $display("FAIL ignore_done_timeout: got no done, expected one"); else n_pass++;
    repeat (30) @(negedge clk);
    n_checks++; if (done_cnt !== 1) $display("FAIL ignore_done_count: got %0d, expected 1", done_cnt); else n_pass++;
    n_checks++; if (win0 !== 3) $display("FAIL ignore_windows: got %0d, expected 3", win0); else n_pass++;
    n_checks++; if (busy_len !== FRAME_BUSY) $display("FAIL ignore_busy_len: got %0d, expected %0d", busy_len, FRAME_BUSY); else n_pass++;
    n_checks++; if (exp0.size() !== 0) $display("FAIL ignore_missing: got %0d bytes left, expected 0", exp0.size()); else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("FAIL ignore_requeued: got busy=%b, expected 0", busy0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit reached;
    clear_stats();
    pulse_start(64'hA5A5_5A5A_0F0F_F0F0, 8'h00);
    push_frame(64'hA5A5_5A5A_0F0F_F0F0, 8'h00);
    reached = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      @(negedge clk);
      if (win0 == 2) reached = 1'b1;
    end
    n_checks++;
    if (!reached) $display("FAIL rstmid_reach_frame2: got %0d windows, expected 2", win0); else n_pass++;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({stb0, clko0, dio0, busy0, done0} !== 5'b11100)
      $display("FAIL rstmid_abort: got %b, expected 11100", {stb0, clko0, dio0, busy0, done0});
    else n_pass++;
    repeat (700) @(negedge clk);
    n_checks++; if (done_cnt !== 0) $display("FAIL rstmid_no_done: got %0d, expected 0", done_cnt); else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("FAIL rstmid_busy: got %b, expected 0", busy0); else n_pass++;
    exp0.delete();
    exp1.delete();
    test_frame("after_rst", 64'h6D7D_077F_6F77_7C39, 8'h00);
  endtask

  task automatic test_back_to_back();
    bit seen;
    clear_stats();
    pulse_start(64'h0706_0504_0302_0100, 8'h00);
    push_frame(64'h0706_0504_0302_0100, 8'h00);
    wait_done(seen);
    n_checks++;
    if (!seen) $display("FAIL b2b_first_timeout: got no done, expected one"); else n_pass++;
    seg_data = 64'hF0E1_D2C3_B4A5_9687; led = 8'h00; start = 1'b1;
    push_frame(64'hF0E1_D2C3_B4A5_9687, 8'h00);
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy0 !== 1'b1) $display("FAIL b2b_accept: got busy=%b, expected 1", busy0); else n_pass++;
    wait_done(seen);
    n_checks++;
    if (!seen) $display("FAIL b2b_second_timeout: got no done, expected one"); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (done_cnt !== 2) $display("FAIL b2b_done_count: got %0d, expected 2", done_cnt); else n_pass++;
    n_checks++; if (win0 !== 6) $display("FAIL b2b_windows: got %0d, expected 6", win0); else n_pass++;
    n_checks++; if (busy_len !== FRAME_BUSY) $display("FAIL b2b_busy_len: got %0d, expected %0d", busy_len, FRAME_BUSY); else n_pass++;
    n_checks++; if (exp0.size() !== 0) $display("FAIL b2b_missing: got %0d bytes left, expected 0", exp0.size()); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seg_data = '0; led = '0;
    test_reset();
    test_frame("frame", 64'h3F06_5B4F_6667_7D07, 8'h00);
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_frame("led", 64'h0102_0408_1020_4080, 8'h81);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
